// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned BLOCK_BITS   = 256;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned WORD_PER_BLK = 8;
  localparam int unsigned WORD_IDX_W   = $clog2(WORD_PER_BLK);

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    F_SCAN,
    F_WB,
    F_DONE
  } state_e;

  // Store size encoding: 0 means a full word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    size_to_bytes = (size == 2'd0) ? 3'd4 : {1'b0, size};
  endfunction

  // Bit b set means big-endian byte b (bits [31-8b -: 8]) is written.
  function automatic logic [3:0] size_to_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [2:0] n;
    n = size_to_bytes(size);
    size_to_mask = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) >= {1'b0, offset} && 3'(b) < ({1'b0, offset} + n)) size_to_mask[b] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/data_cache_dm_if.sv
// MEM-side request port and DM-side block port of the data cache.
interface data_cache_dm_if
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0]     data_address_2DC;
  logic                  read_2DC;
  logic                  write_2DC;
  logic [WORD_W-1:0]     data_write_2DC;
  logic [1:0]            data_write_size_2DC;
  logic                  flush_2DC;
  logic [WORD_W-1:0]     data_read_fDC;
  logic                  data_valid_fDC;
  logic                  flush_done;
  logic [ADDR_W-1:0]     data_address_2DM;
  logic                  dBlkRead;
  logic                  dBlkWrite;
  logic [BLOCK_BITS-1:0] block_write_2DM;
  logic [BLOCK_BITS-1:0] block_read_fDM;
  logic                  block_read_fDM_valid;
  logic                  block_write_fDM_valid;

  // Cache side.
  modport slave (
    input  data_address_2DC, read_2DC, write_2DC, data_write_2DC, data_write_size_2DC,
           flush_2DC, block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
    output data_read_fDC, data_valid_fDC, flush_done, data_address_2DM, dBlkRead,
           dBlkWrite, block_write_2DM
  );

  // Environment side: MEM requester plus DM responder.
  modport master (
    output data_address_2DC, read_2DC, write_2DC, data_write_2DC, data_write_size_2DC,
           flush_2DC, block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
    input  data_read_fDC, data_valid_fDC, flush_done, data_address_2DM, dBlkRead,
           dBlkWrite, block_write_2DM
  );
endinterface

// File: rtl/dcache_store_merge.sv
// Merges a 1..4 byte big-endian store into one word of a cache line.
module dcache_store_merge
  import dcache_pkg::*;
(
  input  logic [BLOCK_BITS-1:0] line_i,
  input  logic [WORD_IDX_W-1:0] word_idx_i,
  input  logic [1:0]            offset_i,
  input  logic [1:0]            size_i,
  input  logic [WORD_W-1:0]     data_i,
  output logic [BLOCK_BITS-1:0] line_o
);

  logic [3:0]        mask;
  logic [2:0]        rem;
  logic [4:0]        shamt;
  logic [WORD_W-1:0] aligned;
  logic [WORD_W-1:0] word;

  always_comb begin
    mask    = size_to_mask(size_i, offset_i);
    // Right-aligned data moves up so its first byte lands at offset_i.
    rem     = 3'd4 - size_to_bytes(size_i) - {1'b0, offset_i};
    shamt   = 5'({rem, 3'b000});
    aligned = data_i << shamt;
    word    = line_i[{word_idx_i, 5'b00000} +: WORD_W];
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) word[31-8*b -: 8] = aligned[31-8*b -: 8];
    end
    line_o = line_i;
    line_o[{word_idx_i, 5'b00000} +: WORD_W] = word;
  end

endmodule

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache with flush/invalidate.
module data_cache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input logic            CLK,
  input logic            RESET,
  data_cache_dm_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - 5 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [TAG_W-1:0]      tag_d  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_d [NUM_LINES];

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_IDX_W-1:0] req_word;
  logic [1:0]            req_off;
  logic                  req_c;
  logic                  hit_c;
  logic [BLOCK_BITS-1:0] merged_line;

  assign req_idx  = bus.data_address_2DC[IDX_W+4:5];
  assign req_tag  = bus.data_address_2DC[ADDR_W-1:IDX_W+5];
  assign req_word = bus.data_address_2DC[4:2];
  assign req_off  = bus.data_address_2DC[1:0];

  // Flush outranks loads/stores; hits only complete from IDLE.
  assign req_c = (bus.read_2DC || bus.write_2DC) && !bus.flush_2DC;
  assign hit_c = (state_q == IDLE) && req_c && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign bus.data_valid_fDC = hit_c;
  assign bus.data_read_fDC  = (hit_c && bus.read_2DC) ?
                              data_q[req_idx][{req_word, 5'b00000} +: WORD_W] : '0;

  dcache_store_merge u_merge (
    .line_i     (data_q[req_idx]),
    .word_idx_i (req_word),
    .offset_i   (req_off),
    .size_i     (bus.data_write_size_2DC),
    .data_i     (bus.data_write_2DC),
    .line_o     (merged_line)
  );

  always_comb begin
    state_d              = state_q;
    scan_idx_d           = scan_idx_q;
    valid_d              = valid_q;
    dirty_d              = dirty_q;
    tag_d                = tag_q;
    data_d               = data_q;
    bus.dBlkRead         = 1'b0;
    bus.dBlkWrite        = 1'b0;
    bus.data_address_2DM = '0;
    bus.block_write_2DM  = '0;
    bus.flush_done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.flush_2DC) begin
          scan_idx_d = '0;
          state_d    = F_SCAN;
        end else if (hit_c) begin
          if (bus.write_2DC) begin
            data_d[req_idx]  = merged_line;
            dirty_d[req_idx] = 1'b1;
          end
        end else if (req_c) begin
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FILL;
        end
      end
      WB: begin
        bus.dBlkWrite        = 1'b1;
        bus.data_address_2DM = {tag_q[req_idx], req_idx, 5'b00000};
        bus.block_write_2DM  = data_q[req_idx];
        if (bus.block_write_fDM_valid) begin
          dirty_d[req_idx] = 1'b0;
          state_d          = FILL;
        end
      end
      FILL: begin
        bus.dBlkRead         = 1'b1;
        bus.data_address_2DM = {req_tag, req_idx, 5'b00000};
        if (bus.block_read_fDM_valid) begin
          data_d[req_idx]  = bus.block_read_fDM;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = IDLE;
        end
      end
      F_SCAN: begin
        if (valid_q[scan_idx_q] && dirty_q[scan_idx_q]) begin
          state_d = F_WB;
        end else if (scan_idx_q == LAST_IDX) begin
          valid_d = '0;
          dirty_d = '0;
          state_d = F_DONE;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      // Returns to the same index, which is now clean and advances.
      F_WB: begin
        bus.dBlkWrite        = 1'b1;
        bus.data_address_2DM = {tag_q[scan_idx_q], scan_idx_q, 5'b00000};
        bus.block_write_2DM  = data_q[scan_idx_q];
        if (bus.block_write_fDM_valid) begin
          dirty_d[scan_idx_q] = 1'b0;
          state_d             = F_SCAN;
        end
      end
      F_DONE: begin
        bus.flush_done = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      scan_idx_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
